aes128_round_sequencer: RTL

Iterative AES-128 encryption engine controller. It accepts one plaintext block and one cipher key through a valid/ready handshake. It then runs the subBytes, Shift_Rows, MixColumns and AddRoundKey datapath once per clock for 10 rounds, expanding the round key on the fly, and presents the ciphertext through a second valid/ready handshake. It sits between the system bus front-end and the existing combinational round primitives, and replaces the unclocked single-round path with a sequenced block.

---
 rtl/aes128_round_sequencer.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/aes128_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : aes128_round_sequencer
// Purpose  : Iterative AES-128 encryption engine. Accepts a plaintext block
//            and a cipher key with a valid/ready handshake, runs one full AES
//            round per clock for 10 rounds, expands the round key on the fly,
//            and returns the ciphertext through a second valid/ready handshake.
// Ports    : clk        - sole clock, rising edge
//            rst        - synchronous active-high reset
//            in_valid   - plaintext/key present
//            in_ready   - engine idle and able to accept a block
//            data_in    - plaintext, bits [127:120] = byte s0
//            key_in     - cipher key, same byte order
//            out_valid  - ciphertext valid
//            out_ready  - downstream accepts ciphertext
//            data_out   - ciphertext, stable while out_valid=1
//            round_o    - current round counter (AES_SEQ_ROUND_OUT_EN only)
// Options  : AES_SEQ_ROUND_OUT_EN - when defined, exposes round_o.
// Revision : 1.0 - initial release
// ============================================================================
module aes128_round_sequencer #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
`ifdef AES_SEQ_ROUND_OUT_EN
    ,
    output logic [3:0]   round_o
`endif
);

    localparam logic [3:0] c_LAST_ROUND = 4'(NUM_ROUNDS);

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Round primitives
    // ------------------------------------------------------------------------
    function automatic logic [7:0] f_sbox(input logic [7:0] b);
        return c_SBOX[8 * (255 - int'(b)) +: 8];
    endfunction

    function automatic logic [7:0] f_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] f_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = f_sbox(s[8*i +: 8]);
        end
        return o;
    endfunction

    // Byte k sits at [127-8k -: 8]; state is column-major (k = row + 4*col).
    function automatic logic [127:0] f_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] f_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c      -: 8];
            a1 = s[127 - 32*c - 8  -: 8];
            a2 = s[127 - 32*c - 16 -: 8];
            a3 = s[127 - 32*c - 24 -: 8];
            // 3*x is xtime(x)^x
            o[127 - 32*c      -: 8] = f_xtime(a0) ^ f_xtime(a1) ^ a1 ^ a2 ^ a3;
            o[127 - 32*c - 8  -: 8] = a0 ^ f_xtime(a1) ^ f_xtime(a2) ^ a2 ^ a3;
            o[127 - 32*c - 16 -: 8] = a0 ^ a1 ^ f_xtime(a2) ^ f_xtime(a3) ^ a3;
            o[127 - 32*c - 24 -: 8] = f_xtime(a0) ^ a0 ^ a1 ^ a2 ^ f_xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] f_key_expand(input logic [127:0] k,
                                                  input logic [7:0]   rcon);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        // SubWord(RotWord(w3)) ^ Rcon
        t  = {f_sbox(w3[23:16]), f_sbox(w3[15:8]), f_sbox(w3[7:0]), f_sbox(w3[31:24])}
             ^ {rcon, 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [7:0] f_rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // ------------------------------------------------------------------------
    // Registers and round datapath
    // ------------------------------------------------------------------------
    state_t       r_fsm;
    logic [3:0]   r_rnd;
    logic [127:0] r_state;
    logic [127:0] r_rkey;

    state_t       w_fsm_nxt;
    logic [3:0]   w_rnd_nxt;
    logic [127:0] w_state_nxt;
    logic [127:0] w_rkey_nxt;

    logic [127:0] w_nk;
    logic [127:0] w_sr;
    logic [127:0] w_mc;

    assign w_nk = f_key_expand(r_rkey, f_rcon(r_rnd));
    assign w_sr = f_shift_rows(f_sub_bytes(r_state));
    assign w_mc = f_mix_columns(w_sr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= S_IDLE;
            r_rnd   <= 4'd0;
            r_state <= '0;
            r_rkey  <= '0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_rnd   <= w_rnd_nxt;
            r_state <= w_state_nxt;
            r_rkey  <= w_rkey_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_rnd_nxt   = r_rnd;
        w_state_nxt = r_state;
        w_rkey_nxt  = r_rkey;
        case (r_fsm)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = data_in ^ key_in;
                    w_rkey_nxt  = key_in;
                    w_rnd_nxt   = 4'd1;
                    w_fsm_nxt   = S_ROUND;
                end
            end
            S_ROUND: begin
                if (r_rnd == c_LAST_ROUND) begin
                    // Final round omits MixColumns; rnd stays at the last value.
                    w_state_nxt = w_sr ^ w_nk;
                    w_fsm_nxt   = S_DONE;
                end else begin
                    w_state_nxt = w_mc ^ w_nk;
                    w_rkey_nxt  = w_nk;
                    w_rnd_nxt   = r_rnd + 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_fsm_nxt = S_IDLE;
                    w_rnd_nxt = 4'd0;
                end
            end
            default: begin
                w_fsm_nxt = S_IDLE;
                w_rnd_nxt = 4'd0;
            end
        endcase
    end

    // Outputs depend only on registered state.
    assign in_ready  = (r_fsm == S_IDLE);
    assign out_valid = (r_fsm == S_DONE);
    assign data_out  = r_state;

`ifdef AES_SEQ_ROUND_OUT_EN
    assign round_o = r_rnd;
`endif

endmodule
`default_nettype wire
